// File: rtl/seg_capture_if.sv
// Seven-segment scan bus as seen by seg_capture: raw digit/segment lines in,
// decoded frame out.
interface seg_capture_if;
  logic [7:0]  dig;
  logic [7:0]  segm;
  logic [31:0] value;
  logic [7:0]  dp;
  logic [7:0]  blank;
  logic        frame_valid;
  logic        frame_err;

  modport master (
    output dig, segm,
    input  value, dp, blank, frame_valid, frame_err
  );

  modport slave (
    input  dig, segm,
    output value, dp, blank, frame_valid, frame_err
  );
endinterface

// File: rtl/seg_capture.sv
// Decodes the scanned 8-digit seven-segment bus back into a 32-bit frame.
// Define SEG_CAPTURE_DP_EN to capture decimal points (segm[7]); otherwise dp reads 0.
//
// state   | meaning
// IDLE    | no digit of the current frame accepted yet
// FILL    | some, but not all, digits of the current frame accepted
// PUBLISH | all 8 digits seen; outputs just updated, frame_valid high
module seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seg_capture_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, PUBLISH} state_t;

  state_t      state, state_d;
  logic [7:0]  s_dig, s_seg, in_seg;
  logic [7:0]  cnt, cnt_d;
  logic        sample_match;
  logic [7:0]  seen, seen_d;
  logic        err_acc, err_acc_d;
  logic [31:0] sh_nib, sh_nib_d;
  logic [7:0]  sh_blank, sh_blank_d;
  logic [31:0] value_q;
  logic [7:0]  blank_q;
  logic        frame_err_q;
  logic        one_low, accept;
  logic [2:0]  acc_idx;
  logic [3:0]  dec_nib;
  logic        dec_blank, dec_err;

`ifdef SEG_CAPTURE_DP_EN
  logic [7:0]  sh_dp, sh_dp_d;
  logic [7:0]  dp_q;

  assign in_seg = bus.segm;
  assign bus.dp = dp_q;
`else
  logic        unused_segm_dp;

  // Forcing bit 7 high keeps dp-only activity from disturbing the dwell count.
  assign in_seg         = {1'b1, bus.segm[6:0]};
  assign unused_segm_dp = bus.segm[7];
  assign bus.dp         = 8'h00;
`endif

  // s_* is both the current sample and the "previous" for the incoming one,
  // so cnt always describes how long the registered sample has been stable.
  assign sample_match = ({bus.dig, in_seg} == {s_dig, s_seg});
  assign cnt_d        = !sample_match ? 8'd0 : (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  always_comb begin
    acc_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!s_dig[i]) acc_idx = 3'(i);
    end
  end

  assign one_low = ($countones(~s_dig) == 1);
  assign accept  = (cnt == 8'(STABLE_CYCLES - 1)) && one_low;

  always_comb begin
    dec_nib   = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (s_seg[6:0])
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      7'h7F: dec_blank = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  // An accept landing in the PUBLISH cycle starts the next frame.
  always_comb begin
    sh_nib_d   = sh_nib;
    sh_blank_d = sh_blank;
    seen_d     = (state == PUBLISH) ? 8'h00 : seen;
    err_acc_d  = (state == PUBLISH) ? 1'b0 : err_acc;
    if (accept) begin
      sh_nib_d[{acc_idx, 2'b00} +: 4] = dec_nib;
      sh_blank_d[acc_idx]             = dec_blank;
      seen_d[acc_idx]                 = 1'b1;
      err_acc_d                       = err_acc_d | dec_err;
    end
  end

`ifdef SEG_CAPTURE_DP_EN
  always_comb begin
    sh_dp_d = sh_dp;
    if (accept) sh_dp_d[acc_idx] = ~s_seg[7];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_dp <= 8'h00;
      dp_q  <= 8'h00;
    end else begin
      sh_dp <= sh_dp_d;
      if (state_d == PUBLISH) dp_q <= sh_dp_d;
    end
  end
`endif

  always_comb begin
    state_d = FILL;
    if (seen_d == 8'hFF)      state_d = PUBLISH;
    else if (seen_d == 8'h00) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      s_dig       <= 8'h00;
      s_seg       <= 8'h00;
      cnt         <= 8'd0;
      seen        <= 8'h00;
      err_acc     <= 1'b0;
      sh_nib      <= 32'h0;
      sh_blank    <= 8'h00;
      value_q     <= 32'h0;
      blank_q     <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      state    <= state_d;
      s_dig    <= bus.dig;
      s_seg    <= in_seg;
      cnt      <= cnt_d;
      seen     <= seen_d;
      err_acc  <= err_acc_d;
      sh_nib   <= sh_nib_d;
      sh_blank <= sh_blank_d;
      if (state_d == PUBLISH) begin
        value_q     <= sh_nib_d;
        blank_q     <= sh_blank_d;
        frame_err_q <= err_acc_d;
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.blank       = blank_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.frame_valid = (state == PUBLISH);

endmodule
